// File: rtl/pu_phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pu_phase_sequencer_pkg
//   Shared definitions for the per-cell position-update phase sequencer:
//   null-address constants, the phase state encoding and a small helper
//   for testing the null flag of a 33-bit address.
// -----------------------------------------------------------------------------
package pu_phase_sequencer_pkg;

  // Bit 32 set with zero low bits means "no address".
  localparam logic [32:0] NULL33 = 33'h1_0000_0000;
  // Empty particle entry: bit 96 is the null/end-of-list flag.
  localparam logic [96:0] NULL97 = {1'b1, 96'h0};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_SWAP   = 3'd5
  } phase_state_e;

  function automatic logic addr_is_null(input logic [32:0] addr);
    return addr[32];
  endfunction

endpackage

// File: rtl/pu_phase_sequencer.sv
// -----------------------------------------------------------------------------
// pu_phase_sequencer
//   Per-cell controller that walks one PositionUpdater through a full
//   position-update phase: clear the updater, stream the cell memory into it
//   (holding on back-pressure), wait for global quiescence, null-fill the stale
//   tail slots and swap the double buffer.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   one-cycle phase start request (honoured only when idle)
//   rd_null        in   null flag of the entry at rd_addr (end of list)
//   pu_block       in   updater back-pressure: hold rd_addr
//   pu_we          in   updater write strobe (slots filled)
//   pu_done        in   updater done
//   all_done       in   global done (all cells done, ring empty)
//   rd_addr        out  [32:0] cell memory read address, bit 32 = null
//   rd_en          out  cell memory read enable
//   pu_ready       out  updater internal clear pulse
//   overwrite_addr out  [32:0] updater overwrite address, bit 32 = null
//   cell_id        out  [32:0] constant cell index
//   double_buffer  out  [1:0] one-hot active buffer select
//   stop_we        out  write freeze outside an active phase
//   busy           out  high whenever not idle
//   phase_done     out  one-cycle pulse on phase completion
// -----------------------------------------------------------------------------
import pu_phase_sequencer_pkg::*;

module pu_phase_sequencer #(
  parameter int unsigned DBSIZE    = 256,
  parameter int unsigned CELL_ID   = 0,
  parameter int unsigned QUIET_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rd_null,
  input  logic        pu_block,
  input  logic        pu_we,
  input  logic        pu_done,
  input  logic        all_done,
  output logic [32:0] rd_addr,
  output logic        rd_en,
  output logic        pu_ready,
  output logic [32:0] overwrite_addr,
  output logic [32:0] cell_id,
  output logic [1:0]  double_buffer,
  output logic        stop_we,
  output logic        busy,
  output logic        phase_done
);

  localparam int unsigned WCW = $clog2(DBSIZE) + 1;
  localparam int unsigned QCW = $clog2(QUIET_CYC) + 1;

  localparam logic [WCW-1:0] WCNT_MAX   = WCW'(DBSIZE);
  localparam logic [32:0]    LAST_ADDR  = 33'(DBSIZE - 1);
  localparam logic [QCW-1:0] QUIET_LAST = QCW'(QUIET_CYC - 1);

  phase_state_e   state_q;
  logic [32:0]    rd_addr_q;
  logic           rd_en_q;
  logic           pu_ready_q;
  logic [32:0]    ow_addr_q;
  logic [1:0]     db_q;
  logic           stop_we_q;
  logic           busy_q;
  logic           phase_done_q;
  logic [WCW-1:0] wr_cnt_q;
  logic [WCW-1:0] wr_cnt_d;
  logic [QCW-1:0] quiet_cnt_q;
  logic           quiet_s;
  logic           count_en_s;

  // Slot-fill counter next value: counts updater writes while streaming or
  // draining, saturating at a full buffer.
  always_comb begin
    quiet_s    = pu_done & all_done;
    count_en_s = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    if (count_en_s && pu_we && (wr_cnt_q != WCNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + WCW'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Phase FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= NULL33;
      rd_en_q      <= 1'b0;
      pu_ready_q   <= 1'b0;
      ow_addr_q    <= NULL33;
      db_q         <= 2'b01;
      stop_we_q    <= 1'b1;
      busy_q       <= 1'b0;
      phase_done_q <= 1'b0;
      wr_cnt_q     <= '0;
      quiet_cnt_q  <= '0;
    end else begin
      phase_done_q <= 1'b0;
      wr_cnt_q     <= wr_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_INIT;
            pu_ready_q  <= 1'b1;
            stop_we_q   <= 1'b0;
            busy_q      <= 1'b1;
            rd_addr_q   <= 33'd0;
            wr_cnt_q    <= '0;
            quiet_cnt_q <= '0;
          end else begin
            stop_we_q <= 1'b1;
          end
        end
        ST_INIT: begin
          state_q    <= ST_STREAM;
          pu_ready_q <= 1'b0;
          rd_en_q    <= 1'b1;
        end
        ST_STREAM: begin
          // Back-pressure wins over end-of-list; rd_null is looked at again
          // once the block lifts.
          if (pu_block) begin
            rd_addr_q <= rd_addr_q;
          end else if (rd_null || (rd_addr_q == LAST_ADDR)) begin
            state_q   <= ST_DRAIN;
            rd_addr_q <= NULL33;
            rd_en_q   <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + 33'd1;
          end
        end
        ST_DRAIN: begin
          if (!quiet_s) begin
            quiet_cnt_q <= '0;
          end else if (quiet_cnt_q == QUIET_LAST) begin
            quiet_cnt_q <= '0;
            state_q     <= ST_CLEAR;
            // Use the count including this cycle's write; a full buffer has
            // no stale tail, so the clear pointer stays null.
            ow_addr_q   <= (wr_cnt_d == WCNT_MAX) ? NULL33 : 33'(wr_cnt_d);
          end else begin
            quiet_cnt_q <= quiet_cnt_q + QCW'(1);
          end
        end
        ST_CLEAR: begin
          if (addr_is_null(ow_addr_q) || (ow_addr_q == LAST_ADDR)) begin
            ow_addr_q    <= NULL33;
            state_q      <= ST_SWAP;
            db_q         <= {db_q[0], db_q[1]};
            phase_done_q <= 1'b1;
            stop_we_q    <= 1'b1;
          end else begin
            ow_addr_q <= ow_addr_q + 33'd1;
          end
        end
        ST_SWAP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          // Unreachable encodings recover to a safe idle.
          state_q     <= ST_IDLE;
          rd_addr_q   <= NULL33;
          rd_en_q     <= 1'b0;
          pu_ready_q  <= 1'b0;
          ow_addr_q   <= NULL33;
          stop_we_q   <= 1'b1;
          busy_q      <= 1'b0;
          quiet_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rd_addr        = rd_addr_q;
  assign rd_en          = rd_en_q;
  assign pu_ready       = pu_ready_q;
  assign overwrite_addr = ow_addr_q;
  assign cell_id        = 33'(CELL_ID);
  assign double_buffer  = db_q;
  assign stop_we        = stop_we_q;
  assign busy           = busy_q;
  assign phase_done     = phase_done_q;

endmodule

// File: tb/tb_pu_phase_sequencer.sv
module tb_pu_phase_sequencer;

  localparam logic [32:0] NL = 33'h1_0000_0000;

  logic        clk;
  logic        rst;
  logic        start, rd_null, pu_block, pu_we, pu_done, all_done;
  logic [32:0] rd_addr, overwrite_addr, cell_id;
  logic        rd_en, pu_ready, stop_we, busy, phase_done;
  logic [1:0]  double_buffer;

  int n_pass;
  int n_total;

  pu_phase_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .rd_null(rd_null),
    .pu_block(pu_block), .pu_we(pu_we), .pu_done(pu_done), .all_done(all_done),
    .rd_addr(rd_addr), .rd_en(rd_en), .pu_ready(pu_ready),
    .overwrite_addr(overwrite_addr), .cell_id(cell_id),
    .double_buffer(double_buffer), .stop_we(stop_we), .busy(busy),
    .phase_done(phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, nul, blk, we, pdn, adn;
    logic [32:0] ea;
    logic        een, erdy;
    logic [32:0] eow;
    logic [1:0]  edb;
    logic        estop, ebusy, epd;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    start = 1'b0; rd_null = 1'b0; pu_block = 1'b0;
    pu_we = 1'b0; pu_done = 1'b0; all_done = 1'b0;
  endtask

  task automatic chk_idle(input string nm, input logic [1:0] edb);
    chk({nm, " rd_addr"}, rd_addr, NL);
    chk({nm, " rd_en"}, 33'(rd_en), 33'd0);
    chk({nm, " pu_ready"}, 33'(pu_ready), 33'd0);
    chk({nm, " ow"}, overwrite_addr, NL);
    chk({nm, " db"}, 33'(double_buffer), 33'(edb));
    chk({nm, " stop_we"}, 33'(stop_we), 33'd1);
    chk({nm, " busy"}, 33'(busy), 33'd0);
    chk({nm, " phase_done"}, 33'(phase_done), 33'd0);
  endtask

  // One random phase checked against a phase-level model: expected address
  // trace from list length and per-address hold counts, expected clear range
  // from the saturated write count, clear entry after a run of 4 quiet cycles.
  task automatic random_phase(input int ph, input logic [1:0] db_before);
    int nullpos, last, idx, guard, we_cnt, run, wr, a;
    int holds[256];
    logic [32:0] exp_q[$];
    logic q;
    logic [1:0] db_after;
    db_after = {db_before[0], db_before[1]};
    nullpos = ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(0, 20));
    last = (nullpos > 255) ? 255 : nullpos;
    for (int i = 0; i < 256; i++) holds[i] = 0;
    for (int i = 0; i <= last; i++) begin
      holds[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int k = 0; k <= holds[i]; k++) exp_q.push_back(33'(i));
    end
    clr_in();
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("rp%0d init pu_ready", ph), 33'(pu_ready), 33'd1);
    chk($sformatf("rp%0d init rd_addr", ph), rd_addr, 33'd0);
    step();
    chk($sformatf("rp%0d latency rd_en", ph), 33'(rd_en), 33'd1);
    idx = 0; guard = 0; we_cnt = 0;
    while (rd_en === 1'b1 && guard < 2000) begin
      chk($sformatf("rp%0d rd_addr[%0d]", ph, idx), rd_addr,
          (idx < exp_q.size()) ? exp_q[idx] : NL);
      idx++;
      a = int'(rd_addr[7:0]);
      rd_null = !rd_addr[32] && (rd_addr[31:0] >= 32'(nullpos));
      pu_block = (holds[a] > 0);
      if (holds[a] > 0) holds[a]--;
      pu_we = 1'($urandom_range(0, 1));
      if (pu_we) we_cnt++;
      guard++;
      step();
    end
    clr_in();
    chk($sformatf("rp%0d stream_len", ph), 33'(idx), 33'(exp_q.size()));
    chk($sformatf("rp%0d drain rd_addr", ph), rd_addr, NL);
    wr = (we_cnt > 256) ? 256 : we_cnt;
    run = 0; guard = 0;
    while (run < 4 && guard < 200) begin
      chk($sformatf("rp%0d drain ow", ph), overwrite_addr, NL);
      q = ($urandom_range(0, 3) != 0);
      if (q) begin
        pu_done = 1'b1; all_done = 1'b1;
      end else begin
        pu_done = 1'($urandom_range(0, 1)); all_done = ~pu_done;
      end
      start = ($urandom_range(0, 9) == 0);
      run = q ? run + 1 : 0;
      guard++;
      step();
    end
    clr_in();
    chk($sformatf("rp%0d drain_timeout", ph), 33'(run), 33'd4);
    if (wr >= 256) begin
      chk($sformatf("rp%0d clear null", ph), overwrite_addr, NL);
      step();
    end else begin
      for (int v = wr; v < 256; v++) begin
        chk($sformatf("rp%0d clear ow", ph), overwrite_addr, 33'(v));
        step();
      end
    end
    chk($sformatf("rp%0d swap pd", ph), 33'(phase_done), 33'd1);
    chk($sformatf("rp%0d swap db", ph), 33'(double_buffer), 33'(db_after));
    chk($sformatf("rp%0d swap stop_we", ph), 33'(stop_we), 33'd1);
    chk($sformatf("rp%0d swap ow", ph), overwrite_addr, NL);
    step();
    chk_idle($sformatf("rp%0d idle", ph), db_after);
  endtask

  initial begin
    int cnt;
    logic [1:0] db_exp;
    n_pass = 0; n_total = 0;
    clr_in();
    rst = 1'b0;
    // rows: st nul blk we pdn adn | rd_addr en rdy ow db stop busy pd
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 33'd0,1'b0,1'b1,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 33'd0,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 33'd1,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 33'd1,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 33'd1,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 33'd2,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 33'd3,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 33'd3,1'b1,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, NL,1'b0,1'b0,NL,2'b01,1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, NL,1'b0,1'b0,33'd3,2'b01,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, NL,1'b0,1'b0,33'd4,2'b01,1'b0,1'b1,1'b0};

    step(); step();
    chk_idle("reset", 2'b01);
    chk("cell_id", cell_id, 33'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle("post_reset", 2'b01);

    // Table phase: block holds, block-vs-null, quiet run broken, start in DRAIN.
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].st; rd_null = tbl[i].nul; pu_block = tbl[i].blk;
      pu_we = tbl[i].we; pu_done = tbl[i].pdn; all_done = tbl[i].adn;
      step();
      chk($sformatf("row%0d rd_addr", i), rd_addr, tbl[i].ea);
      chk($sformatf("row%0d rd_en", i), 33'(rd_en), 33'(tbl[i].een));
      chk($sformatf("row%0d pu_ready", i), 33'(pu_ready), 33'(tbl[i].erdy));
      chk($sformatf("row%0d ow", i), overwrite_addr, tbl[i].eow);
      chk($sformatf("row%0d db", i), 33'(double_buffer), 33'(tbl[i].edb));
      chk($sformatf("row%0d stop_we", i), 33'(stop_we), 33'(tbl[i].estop));
      chk($sformatf("row%0d busy", i), 33'(busy), 33'(tbl[i].ebusy));
      chk($sformatf("row%0d phase_done", i), 33'(phase_done), 33'(tbl[i].epd));
    end
    clr_in();
    for (int v = 5; v < 256; v++) begin
      step();
      chk("tail ow", overwrite_addr, 33'(v));
    end
    step();
    chk("t2 swap pd", 33'(phase_done), 33'd1);
    chk("t2 swap db", 33'(double_buffer), 33'(2'b10));
    chk("t2 swap stop_we", 33'(stop_we), 33'd1);
    chk("t2 swap ow", overwrite_addr, NL);
    step();
    chk_idle("t2 idle", 2'b10);

    // Reset in mid-stream at address 5.
    start = 1'b1; step(); start = 1'b0; step();
    for (int i = 0; i < 5; i++) step();
    chk("t1 rd_addr before reset", rd_addr, 33'd5);
    #2 rst = 1'b0;
    #1 chk_idle("t1 async reset", 2'b01);
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle("t1 after release", 2'b01);

    // Full buffer: 256 writes saturate; CLEAR is one null cycle.
    start = 1'b1; step(); start = 1'b0; step();
    cnt = 0;
    pu_we = 1'b1;
    while (rd_en === 1'b1 && cnt < 400) begin
      cnt++;
      step();
    end
    chk("t5 stream cycles", 33'(cnt), 33'd256);
    step(); step();
    pu_done = 1'b1; all_done = 1'b1;
    for (int i = 0; i < 4; i++) step();
    clr_in();
    chk("t5 clear ow", overwrite_addr, NL);
    chk("t5 clear pd", 33'(phase_done), 33'd0);
    chk("t5 clear busy", 33'(busy), 33'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (phase_done === 1'b1) cnt++;
      if (i == 0) chk("t5 swap db", 33'(double_buffer), 33'(2'b10));
    end
    chk("t5 pd pulses", 33'(cnt), 33'd1);
    chk_idle("t5 idle", 2'b10);

    // Random phases; the first one brings the buffer back to 01.
    db_exp = 2'b10;
    for (int p = 0; p < 6; p++) begin
      random_phase(p, db_exp);
      db_exp = {db_exp[0], db_exp[1]};
    end
    chk("final db", 33'(double_buffer), 33'(2'b10));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
